// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: state encoding,
// counter sizing and default cycle counts for the 50 MHz fabric clock.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_RELEASED     = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_HELD         = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } btn_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_LONG_CYCLES     = 50000000;

    // Bits needed to count 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset level.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Synchronises, debounces and classifies a raw push-button into registered
// press / release / long-press strobes plus a debounced and a toggled level.
module button_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic toggle_q
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HW = cnt_width(LONG_CYCLES);

    logic          sync_q;
    logic          p;
    btn_state_e    state, state_n;
    logic [DW-1:0] deb_cnt, deb_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic          long_seen, long_seen_n;
    logic          level_n, toggle_n, press_n, release_n, long_n;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (sync_q)
    );

    assign p = sync_q ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RELEASED;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_seen     <= 1'b0;
            btn_level     <= 1'b0;
            toggle_q      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_n;
            deb_cnt       <= deb_n;
            hold_cnt      <= hold_n;
            long_seen     <= long_seen_n;
            btn_level     <= level_n;
            toggle_q      <= toggle_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
        end
    end

    // Next state, counters and registered-output next values.
    always_comb begin
        state_n     = state;
        deb_n       = deb_cnt;
        hold_n      = hold_cnt;
        long_seen_n = long_seen;
        level_n     = btn_level;
        toggle_n    = toggle_q;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;

        case (state)
            ST_RELEASED: begin
                if (p) begin
                    state_n = ST_PRESS_WAIT;
                    deb_n   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!p) begin
                    state_n = ST_RELEASED;
                end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    state_n  = ST_PRESSED;
                    press_n  = 1'b1;
                    level_n  = 1'b1;
                    toggle_n = ~toggle_q;
                    hold_n   = '0;
                end else begin
                    deb_n = deb_cnt + DW'(1);
                end
            end
            ST_PRESSED: begin
                if (!p) begin
                    state_n = ST_RELEASE_WAIT;
                    deb_n   = '0;
                end else if (hold_cnt == HW'(LONG_CYCLES - 1)) begin
                    state_n     = ST_HELD;
                    long_n      = 1'b1;
                    long_seen_n = 1'b1;
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            ST_HELD: begin
                if (!p) begin
                    state_n = ST_RELEASE_WAIT;
                    deb_n   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // A bounce back to pressed resumes where the press left off.
                if (p) begin
                    state_n = long_seen ? ST_HELD : ST_PRESSED;
                end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    state_n     = ST_RELEASED;
                    release_n   = 1'b1;
                    level_n     = 1'b0;
                    long_seen_n = 1'b0;
                end else begin
                    deb_n = deb_cnt + DW'(1);
                end
            end
            default: begin
                state_n = ST_RELEASED;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: one active-low and one active-high instance
// driven by the same logical press stream, scored against a run-length model.
module tb_button_debounce;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;

    typedef struct {
        int unsigned edge_no;
        logic        p;
        logic        r;
        logic        l;
    } ev_t;

    logic clk;
    logic rst_n;
    logic pr;
    logic btn_a, btn_b;
    logic lvl_a, pp_a, rp_a, lp_a, tq_a;
    logic lvl_b, pp_b, rp_b, lp_b, tq_b;

    int n_checks = 0;
    int n_fail   = 0;

    assign btn_a = ~pr;
    assign btn_b = pr;

    button_debounce #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_a),
        .btn_level(lvl_a), .press_pulse(pp_a), .release_pulse(rp_a),
        .long_pulse(lp_a), .toggle_q(tq_a)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_b),
        .btn_level(lvl_b), .press_pulse(pp_b), .release_pulse(rp_b),
        .long_pulse(lp_b), .toggle_q(tq_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: level flips after DEB+1 consecutive disagreeing samples;
    // long fires on the LONG-th cycle where a pressed sample follows a pressed sample.
    ev_t         exp_q[$];
    int unsigned edge_no = 0;
    logic        d1, d2, last_s, m_level, m_toggle, long_done;
    int unsigned run, hcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 = 1'b0; d2 = 1'b0; last_s = 1'b0;
            m_level = 1'b0; m_toggle = 1'b0; long_done = 1'b0;
            run = 0; hcnt = 0;
            exp_q.delete();
        end else begin
            logic s, pe, re, le;
            ev_t  e;
            edge_no++;
            s  = d2;
            d2 = d1;
            d1 = pr;
            pe = 1'b0; re = 1'b0; le = 1'b0;
            run = (s != m_level) ? run + 1 : 0;
            if (run == DEB + 1) begin
                m_level = s;
                run = 0;
                if (s) begin
                    pe = 1'b1;
                    m_toggle = ~m_toggle;
                    hcnt = 0;
                    long_done = 1'b0;
                end else begin
                    re = 1'b1;
                end
            end else if (m_level && s && last_s && !long_done) begin
                hcnt++;
                if (hcnt == LONG) begin
                    le = 1'b1;
                    long_done = 1'b1;
                end
            end
            last_s = s;
            if (pe || re || le) begin
                e.edge_no = edge_no; e.p = pe; e.r = re; e.l = le;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: pops an expected event whenever either DUT strobes or one is due.
    int unsigned press_cnt = 0, release_cnt = 0, long_cnt = 0;
    int unsigned press_edge = 0, release_edge = 0, long_edge = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            logic any_a, any_b, due;
            ev_t  e;
            any_a = pp_a | rp_a | lp_a;
            any_b = pp_b | rp_b | lp_b;
            due   = 1'b0;
            if (exp_q.size() > 0) begin
                if (exp_q[0].edge_no <= edge_no) due = 1'b1;
            end
            if (due) begin
                e = exp_q.pop_front();
                check("event_edge", edge_no, e.edge_no);
                check("strobes_a", {29'd0, pp_a, rp_a, lp_a}, {29'd0, e.p, e.r, e.l});
                check("strobes_b", {29'd0, pp_b, rp_b, lp_b}, {29'd0, e.p, e.r, e.l});
            end else if (any_a || any_b) begin
                check("unexpected_strobe_a", {29'd0, pp_a, rp_a, lp_a}, 32'd0);
                check("unexpected_strobe_b", {29'd0, pp_b, rp_b, lp_b}, 32'd0);
            end
            check("level_a", {31'd0, lvl_a}, {31'd0, m_level});
            check("level_b", {31'd0, lvl_b}, {31'd0, m_level});
            check("toggle_a", {31'd0, tq_a}, {31'd0, m_toggle});
            check("toggle_b", {31'd0, tq_b}, {31'd0, m_toggle});
            if (pp_a) begin press_cnt++;   press_edge   = edge_no; end
            if (rp_a) begin release_cnt++; release_edge = edge_no; end
            if (lp_a) begin long_cnt++;    long_edge    = edge_no; end
        end
    end

    task automatic hold(input logic v, input int unsigned n);
        pr = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int unsigned s0, pc, rc, lc, p_first;
        pr    = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs_a", {27'd0, lvl_a, pp_a, rp_a, lp_a, tq_a}, 32'd0);
        check("reset_outs_b", {27'd0, lvl_b, pp_b, rp_b, lp_b, tq_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 5);

        // Clean press held long enough for a long press, then a clean release.
        s0 = edge_no; pc = press_cnt; lc = long_cnt; rc = release_cnt;
        hold(1'b1, 37);
        check("press_edge_clean", press_edge, s0 + 7);
        check("press_count_clean", press_cnt - pc, 1);
        check("toggle_first_press", {31'd0, tq_a}, 32'd1);
        p_first = press_edge;
        check("long_edge_clean", long_edge, p_first + LONG);
        check("long_count_clean", long_cnt - lc, 1);
        s0 = edge_no;
        hold(1'b0, 12);
        check("release_edge_clean", release_edge, s0 + 7);
        check("release_count_clean", release_cnt - rc, 1);
        check("level_after_release", {31'd0, lvl_a}, 32'd0);

        // Press glitches of 1, 2 and 3 cycles are rejected.
        pc = press_cnt;
        hold(1'b1, 1); hold(1'b0, 2);
        hold(1'b1, 2); hold(1'b0, 2);
        hold(1'b1, 3); hold(1'b0, 6);
        check("glitch_no_press", press_cnt - pc, 0);
        check("glitch_level", {31'd0, lvl_a}, 32'd0);
        s0 = edge_no;
        hold(1'b1, 10);
        check("press_after_glitch", press_cnt - pc, 1);
        check("press_edge_after_glitch", press_edge, s0 + 7);
        check("toggle_second_press", {31'd0, tq_a}, 32'd0);
        hold(1'b0, 12);

        // Release bounce at hold count 10 delays long by three cycles.
        s0 = edge_no; lc = long_cnt; rc = release_cnt;
        hold(1'b1, 15); hold(1'b0, 2); hold(1'b1, 30);
        check("bounce_no_release", release_cnt - rc, 0);
        check("bounce_long_edge", long_edge, s0 + 7 + LONG + 3);
        check("bounce_long_count", long_cnt - lc, 1);
        check("bounce_level", {31'd0, lvl_a}, 32'd1);

        // Reset while HELD clears everything at once; held button re-presses.
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outs_a", {27'd0, lvl_a, pp_a, rp_a, lp_a, tq_a}, 32'd0);
        check("midreset_outs_b", {27'd0, lvl_b, pp_b, rp_b, lp_b, tq_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = edge_no; pc = press_cnt; rc = release_cnt;
        hold(1'b1, 12);
        check("post_reset_press_edge", press_edge, s0 + 7);
        check("post_reset_press_count", press_cnt - pc, 1);
        check("post_reset_no_release", release_cnt - rc, 0);
        hold(1'b0, 12);

        // Random bouncy traffic with occasional long holds.
        repeat (120) begin
            if ($urandom_range(0, 7) == 0) hold(1'b1, $urandom_range(25, 40));
            else hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        hold(1'b0, 15);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Input-side conditioner for the LED-blink fabric design. It takes a raw, asynchronous, bouncing push-button pin, then synchronises, debounces and classifies it into clean single-cycle press, release and long-press events plus a press-toggled level. Its outputs feed the MSS GPIO inputs and the fabric LED logic, complementing the output-side LED drive path.

## Interface
- DEBOUNCE_CYCLES, 500000: cycles the input must be stable to accept a change (10 ms at 50 MHz); ≥2
- LONG_CYCLES, 50000000: cycles after press_pulse before long_pulse fires (1 s at 50 MHz); ≥2
- ACTIVE_LOW, 1: 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed
- clk  input  1  single system clock (fabric CCC output)
- rst_n  input  1  asynchronous, active-low reset
- btn_in  input  1  raw button pin, asynchronous to clk
- btn_level  output  1  debounced state, 1 = pressed
- press_pulse  output  1  one-cycle strobe on accepted press
- release_pulse  output  1  one-cycle strobe on accepted release
- long_pulse  output  1  one-cycle strobe when press held LONG_CYCLES
- toggle_q  output  1  flips on every press_pulse

## Operation
- btn_in passes through a 2-flop synchroniser, then is XOR-normalised by ACTIVE_LOW to p (1 = pressed).
- Synchroniser flops reset to the released level.
- One shared debounce counter deb_cnt, width $clog2(DEBOUNCE_CYCLES). One hold counter hold_cnt, width $clog2(LONG_CYCLES).
- FSM states: RELEASED, PRESS_WAIT, PRESSED, HELD, RELEASE_WAIT.
  - RELEASED: on p=1, go to PRESS_WAIT and set deb_cnt=0.
  - PRESS_WAIT: if p=0, return to RELEASED (glitch rejected, no output). If deb_cnt==DEBOUNCE_CYCLES-1, go to PRESSED, pulse press_pulse, set btn_level=1, invert toggle_q, set hold_cnt=0. Otherwise increment deb_cnt.
  - PRESSED: if p=0, go to RELEASE_WAIT with deb_cnt=0 and hold_cnt frozen. Else if hold_cnt==LONG_CYCLES-1, go to HELD and pulse long_pulse. Else increment hold_cnt.
  - HELD: on p=0, go to RELEASE_WAIT with deb_cnt=0.
  - RELEASE_WAIT: if p=1, return to the origin state (PRESSED or HELD, tracked by a long_seen flag) and hold_cnt resumes. If deb_cnt==DEBOUNCE_CYCLES-1, go to RELEASED, pulse release_pulse, set btn_level=0, clear long_seen.
- Only one event strobe can be high in any cycle; the FSM structure guarantees it.
- long_pulse fires at most once per press. Bounces during the release window never produce a second long_pulse or press_pulse.
- Reset (asynchronous, any state): FSM=RELEASED, counters=0, long_seen=0. All outputs are 0: btn_level, press_pulse, release_pulse, long_pulse and toggle_q.
- A button held pressed through reset deassertion must debounce normally and produce press_pulse; no event is lost or duplicated.

## Timing
- All outputs are registered; no combinational path from btn_in to any output.
- Number edges from the first clk edge that samples btn_in pressed as edge 1. The synchroniser output is valid after edge 2, PRESS_WAIT is entered at edge 3, and press_pulse and btn_level rise at edge DEBOUNCE_CYCLES+3.
- Release latency is the same: DEBOUNCE_CYCLES+3 edges from a stable release to release_pulse.
- long_pulse occurs exactly LONG_CYCLES edges after press_pulse, provided there were no release bounces. Each rejected release glitch delays long_pulse by the number of cycles spent in RELEASE_WAIT.
- Strobes are high for exactly one cycle.
- Reset assertion is immediate. Deassertion must be synchronised externally to clk.

## Structure
- Shared package/include btn_pkg holds:
  - FSM state encoding localparams (3-bit binary)
  - the clog2-based counter width function
  - default cycle constants for the 50 MHz fabric clock
- Sub-module sync_2ff: 2-flop synchroniser with reset value parameter. It is reused for other MSS-bound fabric inputs.
- The FSM, counters and output registers live in button_debounce.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
- Clean press: btn_in 1→0 held → press_pulse single cycle at edge 7, btn_level=1, toggle_q 0→1. No long_pulse before 20 edges later.
- Bounce rejection: press glitches of 1, 2 and 3 cycles separated by 2-cycle releases → no strobes, btn_level stays 0. A final stable press → exactly one press_pulse.
- Long press: hold 30 cycles past press_pulse → long_pulse exactly 20 edges after press_pulse, exactly once. Release → release_pulse DEBOUNCE_CYCLES+3 edges later, btn_level=0.
- Release bounce: in PRESSED, 2-cycle release glitch at hold_cnt=10 → no release_pulse, state returns to PRESSED, long_pulse delayed by 3 cycles.
- Two full press/release cycles → toggle_q sequence 0→1→0. Repeat with ACTIVE_LOW=0 and inverted stimulus → identical outputs.
- Reset mid-operation: assert rst_n=0 in HELD → all outputs 0 within the same cycle. Release reset with button still pressed → one press_pulse at edge 7 after deassertion, no release_pulse.
